// File: rtl/img_stream_gen_pkg.sv
// Shared video package for the image stream generator and the filter blocks
// that consume its stream.
//   - FSM state encodings of the generator
//   - pattern_sel codes
//   - counter widths and the default 1280x720 timing parameters
package img_stream_gen_pkg;

  localparam int CNT_W  = 11;  // width of the h/v position counters
  localparam int FCNT_W = 16;  // width of the completed-frame counter

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_e;

  typedef enum logic [1:0] {
    PAT_H_RAMP  = 2'd0,
    PAT_V_RAMP  = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_DIAG    = 2'd3
  } pattern_e;

  localparam int DEF_DATA_WIDTH = 8;

  localparam logic [CNT_W-1:0] DEF_H_SYNC  = 11'd40;
  localparam logic [CNT_W-1:0] DEF_H_BACK  = 11'd220;
  localparam logic [CNT_W-1:0] DEF_H_DISP  = 11'd1280;
  localparam logic [CNT_W-1:0] DEF_H_FRONT = 11'd110;
  localparam logic [CNT_W-1:0] DEF_H_TOTAL = 11'd1650;

  localparam logic [CNT_W-1:0] DEF_V_SYNC  = 11'd5;
  localparam logic [CNT_W-1:0] DEF_V_BACK  = 11'd20;
  localparam logic [CNT_W-1:0] DEF_V_DISP  = 11'd720;
  localparam logic [CNT_W-1:0] DEF_V_FRONT = 11'd5;
  localparam logic [CNT_W-1:0] DEF_V_TOTAL = 11'd750;

endpackage

// File: rtl/img_stream_gen_timing_cnt.sv
// img_timing_cnt: horizontal/vertical position counters plus the window
// decodes derived from them. Usable by any block that needs raster timing.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   run          1 = advance the counters, 0 = hold them at position 0
//   hsync/vsync  combinational sync decodes of the current position
//   valid        current position lies inside the active window
//   frame_first  current position is (0,0)
//   frame_last   current position is (H_TOTAL-1, V_TOTAL-1)
//   x, y         0-based offsets into the active window (meaningful when valid)
module img_timing_cnt
  import img_stream_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_SYNC  = DEF_H_SYNC,
  parameter logic [CNT_W-1:0] H_BACK  = DEF_H_BACK,
  parameter logic [CNT_W-1:0] H_DISP  = DEF_H_DISP,
  parameter logic [CNT_W-1:0] H_FRONT = DEF_H_FRONT,
  parameter logic [CNT_W-1:0] H_TOTAL = DEF_H_TOTAL,
  parameter logic [CNT_W-1:0] V_SYNC  = DEF_V_SYNC,
  parameter logic [CNT_W-1:0] V_BACK  = DEF_V_BACK,
  parameter logic [CNT_W-1:0] V_DISP  = DEF_V_DISP,
  parameter logic [CNT_W-1:0] V_FRONT = DEF_V_FRONT,
  parameter logic [CNT_W-1:0] V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y
);

  localparam logic [CNT_W-1:0] HA_START = H_SYNC + H_BACK;
  localparam logic [CNT_W-1:0] HA_END   = HA_START + H_DISP;
  localparam logic [CNT_W-1:0] VA_START = V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] VA_END   = VA_START + V_DISP;

  // Inconsistent timing sets are caught at elaboration, before any cycle runs.
  if (32'(H_TOTAL) != 32'(H_SYNC) + 32'(H_BACK) + 32'(H_DISP) + 32'(H_FRONT)) begin : g_bad_h_total
    $error("img_timing_cnt: H_TOTAL differs from H_SYNC+H_BACK+H_DISP+H_FRONT");
  end
  if (32'(V_TOTAL) != 32'(V_SYNC) + 32'(V_BACK) + 32'(V_DISP) + 32'(V_FRONT)) begin : g_bad_v_total
    $error("img_timing_cnt: V_TOTAL differs from V_SYNC+V_BACK+V_DISP+V_FRONT");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt == H_TOTAL - CNT_W'(1));
  assign v_last = (v_cnt == V_TOTAL - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign hsync       = (h_cnt < H_SYNC);
  assign vsync       = (v_cnt < V_SYNC);
  assign valid       = (h_cnt >= HA_START) && (h_cnt < HA_END) &&
                       (v_cnt >= VA_START) && (v_cnt < VA_END);
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = h_last && v_last;
  assign x           = h_cnt - HA_START;
  assign y           = v_cnt - VA_START;

endmodule

// File: rtl/img_stream_gen.sv
// img_stream_gen: test-pattern video source. Drives the
// img_vsync/img_hsync/img_valid/img_data stream that the filter blocks take
// on their pre_img_* inputs.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        run request (level); a drop finishes the current frame first
//   pattern_sel   0 H-ramp, 1 V-ramp, 2 checker, 3 diagonal (sampled at frame start)
//   img_vsync     frame sync, active high
//   img_hsync     line sync, active high
//   img_valid     active pixel qualifier
//   img_data      pixel value, forced to 0 when img_valid is low
//   frame_done    one-cycle pulse on the last output cycle of a frame
//   frame_cnt     completed-frame count, wraps 65535 -> 0
//   busy          registered "state is RUN or DRAIN"
//
// Stream semantics: there is no back-pressure. Every cycle with img_valid=1
// carries one pixel in img_data; the sink must accept it in that cycle.
// img_hsync/img_vsync are position markers and are independent of img_valid.
//
// Timing: enable seen at edge N moves the FSM to RUN; edge N+1 arms the
// counters at position (0,0); edge N+2 presents that position on the
// outputs. Every output is a flop fed from the counter position, so the
// outputs trail the counters by exactly one cycle.
module img_stream_gen
  import img_stream_gen_pkg::*;
#(
  parameter int               DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [CNT_W-1:0] H_SYNC     = DEF_H_SYNC,
  parameter logic [CNT_W-1:0] H_BACK     = DEF_H_BACK,
  parameter logic [CNT_W-1:0] H_DISP     = DEF_H_DISP,
  parameter logic [CNT_W-1:0] H_FRONT    = DEF_H_FRONT,
  parameter logic [CNT_W-1:0] H_TOTAL    = DEF_H_TOTAL,
  parameter logic [CNT_W-1:0] V_SYNC     = DEF_V_SYNC,
  parameter logic [CNT_W-1:0] V_BACK     = DEF_V_BACK,
  parameter logic [CNT_W-1:0] V_DISP     = DEF_V_DISP,
  parameter logic [CNT_W-1:0] V_FRONT    = DEF_V_FRONT,
  parameter logic [CNT_W-1:0] V_TOTAL    = DEF_V_TOTAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic                  img_vsync,
  output logic                  img_hsync,
  output logic                  img_valid,
  output logic [DATA_WIDTH-1:0] img_data,
  output logic                  frame_done,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic                  busy
);

  gen_state_e        state_q;
  gen_state_e        state_d;
  logic              cnt_run_q;
  logic              cnt_run_d;
  pattern_e          pat_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic              t_hsync;
  logic              t_vsync;
  logic              t_valid;
  logic              t_first;
  logic              t_last;
  logic [CNT_W-1:0]  t_x;
  logic [CNT_W-1:0]  t_y;
  logic              frame_end;
  logic [DATA_WIDTH-1:0] pix_d;

  img_timing_cnt #(
    .H_SYNC (H_SYNC),
    .H_BACK (H_BACK),
    .H_DISP (H_DISP),
    .H_FRONT(H_FRONT),
    .H_TOTAL(H_TOTAL),
    .V_SYNC (V_SYNC),
    .V_BACK (V_BACK),
    .V_DISP (V_DISP),
    .V_FRONT(V_FRONT),
    .V_TOTAL(V_TOTAL)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (cnt_run_q),
    .hsync      (t_hsync),
    .vsync      (t_vsync),
    .valid      (t_valid),
    .frame_first(t_first),
    .frame_last (t_last),
    .x          (t_x),
    .y          (t_y)
  );

  // The counters sit on the last position only while they are running.
  assign frame_end = cnt_run_q && t_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_run_q <= cnt_run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = frame_end ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)         state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The first RUN cycle after IDLE only arms the counters; leaving for IDLE
    // stops them on the same edge that wraps them back to (0,0).
    cnt_run_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
  end

  // Pattern is taken only at position (0,0) so a frame never mixes patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_H_RAMP;
    end else if (t_first) begin
      pat_q <= pattern_e'(pattern_sel);
    end
  end

  always_comb begin
    pix_d = '0;
    case (pat_q)
      PAT_H_RAMP:  pix_d = DATA_WIDTH'(t_x);
      PAT_V_RAMP:  pix_d = DATA_WIDTH'(t_y);
      PAT_CHECKER: pix_d = {DATA_WIDTH{t_x[3] ^ t_y[3]}};
      PAT_DIAG:    pix_d = DATA_WIDTH'(32'(t_x) + 32'(t_y) + 32'(frame_cnt_q));
      default:     pix_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_vsync   <= 1'b0;
      img_hsync   <= 1'b0;
      img_valid   <= 1'b0;
      img_data    <= '0;
      frame_done  <= 1'b0;
      frame_cnt_q <= '0;
      busy        <= 1'b0;
    end else begin
      if (cnt_run_q) begin
        img_vsync  <= t_vsync;
        img_hsync  <= t_hsync;
        img_valid  <= t_valid;
        img_data   <= t_valid ? pix_d : '0;
        frame_done <= t_last;
      end else begin
        img_vsync  <= 1'b0;
        img_hsync  <= 1'b0;
        img_valid  <= 1'b0;
        img_data   <= '0;
        frame_done <= 1'b0;
      end
      // Written every cycle so the count is always a plain register update.
      frame_cnt_q <= frame_cnt_q + FCNT_W'(frame_end);
      busy        <= (state_q != ST_IDLE);
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_img_stream_gen.sv
// Directed bench for img_stream_gen using a small raster:
// H 2/3/8/2/15, V 1/2/4/1/8 -> 120 output cycles per frame, active window
// x = h-5 for h in [5,13), y = v-3 for v in [3,7).
module tb_img_stream_gen;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    pattern_sel;
  logic          img_vsync;
  logic          img_hsync;
  logic          img_valid;
  logic [DW-1:0] img_data;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          busy;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [15:0]   exp_fc   = 16'd0;

  img_stream_gen #(
    .DATA_WIDTH(DW),
    .H_SYNC (11'd2),
    .H_BACK (11'd3),
    .H_DISP (11'd8),
    .H_FRONT(11'd2),
    .H_TOTAL(11'd15),
    .V_SYNC (11'd1),
    .V_BACK (11'd2),
    .V_DISP (11'd4),
    .V_FRONT(11'd1),
    .V_TOTAL(11'd8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .img_vsync  (img_vsync),
    .img_hsync  (img_hsync),
    .img_valid  (img_valid),
    .img_data   (img_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  // Expected {vsync, hsync, valid, data[7:0], frame_done} at output position pos.
  function automatic logic [11:0] model(input int pos, input int pat, input logic [15:0] fc);
    int h, v, x, y;
    logic hs, vs, va, fd;
    logic [7:0] d;
    h  = pos % 15;
    v  = pos / 15;
    hs = (h < 2);
    vs = (v < 1);
    va = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
    x  = h - 5;
    y  = v - 3;
    d  = 8'h00;
    if (va) begin
      case (pat)
        0:       d = 8'(x);
        1:       d = 8'(y);
        2:       d = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
        default: d = 8'(x + y + int'(fc));
      endcase
    end
    fd = (pos == 119);
    return {vs, hs, va, d, fd};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {img_vsync, img_hsync, img_valid, img_data, frame_done};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected %h", obs_vec(), 12'h000);
    end
    n_checks++;
    if (frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_frame_cnt: got %h, expected %h", frame_cnt, 16'd0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({obs_vec(), busy} !== 13'h0) begin
      n_fail++; $display("FAIL idle_wait: got %h, expected %h", {obs_vec(), busy}, 13'h0);
    end
  endtask

  task automatic test_h_ramp();
    logic [11:0] exp_v;
    int nv = 0, nh = 0, ns = 0;
    pattern_sel = 2'd0;
    enable = 1'b1;
    @(negedge clk);  // edge N has passed
    n_checks++;
    if ({img_hsync, img_vsync, busy} !== 3'b000) begin
      n_fail++; $display("FAIL start_edge_n: got %b, expected 000", {img_hsync, img_vsync, busy});
    end
    @(negedge clk);  // edge N+1
    n_checks++;
    if ({img_hsync, img_vsync, busy} !== 3'b001) begin
      n_fail++; $display("FAIL start_edge_n1: got %b, expected 001", {img_hsync, img_vsync, busy});
    end
    for (int p = 0; p < 240; p++) begin
      @(negedge clk);
      exp_v = model(p % 120, 0, exp_fc);
      if (p % 120 == 119) exp_fc++;
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++; $display("FAIL h_ramp_pos%0d: got %h, expected %h", p, obs_vec(), exp_v);
      end
      n_checks++;
      if (frame_cnt !== exp_fc) begin
        n_fail++; $display("FAIL h_ramp_fcnt%0d: got %0d, expected %0d", p, frame_cnt, exp_fc);
      end
      nv += (img_valid === 1'b1) ? 1 : 0;
      nh += (img_hsync === 1'b1) ? 1 : 0;
      ns += (img_vsync === 1'b1) ? 1 : 0;
      if (p % 120 == 119) begin
        n_checks++;
        if ({nv, nh, ns} !== {32'd32, 32'd16, 32'd15}) begin
          n_fail++; $display("FAIL h_ramp_counts: got valid=%0d hsync=%0d vsync=%0d, expected 32 16 15", nv, nh, ns);
        end
        nv = 0; nh = 0; ns = 0;
      end
    end
  endtask

  task automatic test_pattern_switch();
    int pats[4] = '{0, 2, 1, 3};
    int nxt[4]  = '{2, 1, 3, 1};
    logic [11:0] exp_v;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 120; p++) begin
        @(negedge clk);
        exp_v = model(p, pats[k], exp_fc);
        if (p == 119) exp_fc++;
        n_checks++;
        if (obs_vec() !== exp_v) begin
          n_fail++; $display("FAIL pat%0d_pos%0d: got %h, expected %h", pats[k], p, obs_vec(), exp_v);
        end
        n_checks++;
        if (frame_cnt !== exp_fc) begin
          n_fail++; $display("FAIL pat%0d_fcnt%0d: got %0d, expected %0d", pats[k], p, frame_cnt, exp_fc);
        end
        if (p == 60) pattern_sel = 2'(nxt[k]);
      end
    end
  endtask

  task automatic test_drain();
    logic [11:0] exp_v;
    // Frame A: short enable drop that is withdrawn; frame B: real drop at 40.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 120; p++) begin
        @(negedge clk);
        exp_v = model(p, 1, exp_fc);
        if (p == 119) exp_fc++;
        n_checks++;
        if ({obs_vec(), busy} !== {exp_v, 1'b1}) begin
          n_fail++; $display("FAIL drain_f%0d_pos%0d: got %h, expected %h", f, p, {obs_vec(), busy}, {exp_v, 1'b1});
        end
        n_checks++;
        if (frame_cnt !== exp_fc) begin
          n_fail++; $display("FAIL drain_f%0d_fcnt%0d: got %0d, expected %0d", f, p, frame_cnt, exp_fc);
        end
        if (f == 0 && p == 20) enable = 1'b0;
        if (f == 0 && p == 30) enable = 1'b1;
        if (f == 1 && p == 40) enable = 1'b0;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({obs_vec(), busy} !== 13'h0 || frame_cnt !== exp_fc) begin
        n_fail++; $display("FAIL drain_idle%0d: got %h cnt %0d, expected 0 cnt %0d", i, {obs_vec(), busy}, frame_cnt, exp_fc);
      end
    end
  endtask

  task automatic test_reset_restart();
    logic [11:0] exp_v;
    pattern_sel = 2'd0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({img_hsync, img_vsync} !== 2'b00) begin
      n_fail++; $display("FAIL restart_edge_n1: got %b, expected 00", {img_hsync, img_vsync});
    end
    for (int p = 0; p <= 70; p++) begin
      @(negedge clk);
      exp_v = model(p, 0, exp_fc);
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++; $display("FAIL restart_pos%0d: got %h, expected %h", p, obs_vec(), exp_v);
      end
    end
    rst_n = 1'b0;
    enable = 1'b0;
    exp_fc = 16'd0;
    #1;
    n_checks++;
    if ({obs_vec(), busy} !== 13'h0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_reset: got %h cnt %0d, expected 0 cnt 0", {obs_vec(), busy}, frame_cnt);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_done: got %b, expected 0", frame_done);
      end
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({obs_vec(), busy} !== 13'h0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h cnt %0d, expected 0 cnt 0", {obs_vec(), busy}, frame_cnt);
    end
    pattern_sel = 2'd3;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({img_hsync, img_vsync} !== 2'b00) begin
      n_fail++; $display("FAIL reenable_edge_n1: got %b, expected 00", {img_hsync, img_vsync});
    end
    for (int p = 0; p < 120; p++) begin
      @(negedge clk);
      exp_v = model(p, 3, exp_fc);
      if (p == 119) exp_fc++;
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++; $display("FAIL reenable_pos%0d: got %h, expected %h", p, obs_vec(), exp_v);
      end
      n_checks++;
      if (frame_cnt !== exp_fc) begin
        n_fail++; $display("FAIL reenable_fcnt%0d: got %0d, expected %0d", p, frame_cnt, exp_fc);
      end
      if (p == 60) pattern_sel = 2'd0;
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [11:0] exp_v;
    for (int p = 0; p < 120; p++) begin
      @(negedge clk);
      exp_v = model(p, 0, exp_fc);
      if (p == 119) exp_fc++;
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_fail++; $display("FAIL wrap_pos%0d: got %h, expected %h", p, obs_vec(), exp_v);
      end
      n_checks++;
      if (frame_cnt !== exp_fc) begin
        n_fail++; $display("FAIL wrap_fcnt%0d: got %h, expected %h", p, frame_cnt, exp_fc);
      end
      if (p == 100) begin
        force dut.frame_cnt_q = 16'hFFFF;
        exp_fc = 16'hFFFF;
      end
      if (p == 102) release dut.frame_cnt_q;
      if (p == 110) enable = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({obs_vec(), busy} !== 13'h0 || frame_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_end_idle: got %h cnt %h, expected 0 cnt 0000", {obs_vec(), busy}, frame_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_h_ramp();
    test_pattern_switch();
    test_drain();
    test_reset_restart();
    test_frame_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/img_stream_gen.md
IMG_STREAM_GEN -- requirements
Module: img_stream_gen

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 8, pixel width
  H_SYNC, 11'd40, line sync cycles
  H_BACK, 11'd220, line back porch
  H_DISP, 11'd1280, active pixels per line
  H_FRONT, 11'd110, line front porch
  H_TOTAL, 11'd1650, line period
  V_SYNC, 11'd5, frame sync lines
  V_BACK, 11'd20, frame back porch
  V_DISP, 11'd720, active lines
  V_FRONT, 11'd5, frame front porch
  V_TOTAL, 11'd750, frame period in lines
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  enable  in  1  run request, level
  pattern_sel  in  2  0 H-ramp, 1 V-ramp, 2 checker, 3 diagonal
  img_vsync  out  1  frame sync, active high
  img_hsync  out  1  line sync, active high
  img_valid  out  1  active pixel qualifier
  img_data  out  DATA_WIDTH  pixel value, meaningful only when img_valid
  frame_done  out  1  one-cycle pulse, last cycle of a frame
  frame_cnt  out  16  completed-frame count
  busy  out  1  high in RUN or DRAIN

Function
REQ-003 Block SHALL be the transmitting end of the img_vsync/hsync/valid/data stream consumed by the filter blocks, so its outputs connect directly to pre_img_* ports.
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN: IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->RUN when enable=1 again; RUN or DRAIN->IDLE only at end of frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with enable=0.
REQ-005 Frame is never truncated: an enable drop mid-frame SHALL complete the current frame, then enter IDLE.
REQ-006 h_cnt SHALL count 0..H_TOTAL-1 and wrap; v_cnt SHALL increment at h wrap, count 0..V_TOTAL-1, and wrap; both held at 0 in IDLE.
REQ-007 Entering RUN from IDLE SHALL start at h_cnt=v_cnt=0: enable sampled high at edge N gives first img_vsync=img_hsync=1 after edge N+2.
REQ-008 All outputs SHALL be registered, with a fixed 1-cycle latency from the counter position.
REQ-009 Decodes: hsync = h_cnt<H_SYNC; vsync = v_cnt<V_SYNC; valid = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-010 Active coordinates x,y SHALL be 0-based offsets into the active window.
REQ-011 Patterns: 0 -> x mod 2^DATA_WIDTH; 1 -> y mod 2^DATA_WIDTH; 2 -> all-ones if x[3]^y[3] else 0; 3 -> (x+y+frame_cnt) mod 2^DATA_WIDTH.
REQ-012 img_data SHALL be 0 whenever img_valid=0.
REQ-013 pattern_sel SHALL be latched only at h_cnt=v_cnt=0 and held for the whole frame; mid-frame changes take effect next frame.
REQ-014 frame_done SHALL pulse on the output cycle of the last frame position; frame_cnt SHALL increment at that same cycle and wrap 65535->0.
REQ-015 In IDLE, all sync, valid and data outputs SHALL be 0, and busy SHALL be 0.

Reset
REQ-016 rst_n low SHALL asynchronously force state IDLE, counters 0, latched pattern 0, and every output 0 (frame_cnt included).
REQ-017 Reset asserted mid-frame SHALL abort the frame with no frame_done; after release, the block waits in IDLE for enable.

Structure
REQ-018 The shared video package SHALL hold FSM state encodings, pattern_sel codes, and the timing-parameter defaults also used by the filters.
REQ-019 A single sub-module, img_timing_cnt (h/v counters plus window decodes), SHALL be natural and reusable by other sinks.
REQ-020 A simulation-only check SHALL flag H_TOTAL != H_SYNC+H_BACK+H_DISP+H_FRONT, and likewise for V.

Verification (small params: H 2/3/8/2/15, V 1/2/4/1/8, DATA_WIDTH 8; frame = 120 cycles)
REQ-021 enable held high, pattern 0 -> 32 valid cycles per frame, each line 0..7, frame_done every 120 cycles, frame_cnt 0->1->2.
REQ-022 enable rises at edge N -> vsync and hsync high from N+2, hsync 2 cycles per 15, vsync 15 cycles per frame.
REQ-023 enable drops at cycle 40 of a frame -> frame completes (frame_done at cycle 119), busy=0 next cycle, outputs 0 thereafter.
REQ-024 pattern_sel 0->2 at cycle 60 -> current frame stays ramp; next frame rows y=0..3 read 00,00,00,00,00,00,00,00 (x<8, y<8) checker row.
REQ-025 rst_n pulse at cycle 70 -> all outputs 0 immediately, no frame_done, frame_cnt 0; re-enable restarts the frame at position 0.
REQ-026 frame_cnt preloaded near wrap via 65536 frames, or a forced value in sim -> 65535->0 rollover at frame_done.
